// File: rtl/mac_array_os_ctrl.sv
// mac_array_os_ctrl
// -----------------------------------------------------------------------------
// Sequencer for an output-stationary MAC array. For each tile job it clears
// the accumulators, streams k_len activation/weight reads, waits out the
// systolic skew, and then drains `row` psum vectors into the psum SRAM.
//
// Optional feature macro: MAC_OS_CTRL_PERF_EN
//   defined   : cycle_cnt counts busy cycles of the most recent job
//               (cleared on start acceptance, saturating, held in IDLE).
//   undefined : cycle_cnt is tied to zero.
//
// Parameters
//   row      array rows; number of psum vectors drained per job
//   col      array columns; width of array_valid
//   addr_bw  SRAM address width
//
// Ports
//   clk           in   clock, rising edge
//   reset         in   asynchronous active-low reset
//   start         in   job request (see handshake note below)
//   k_len         in   accumulation depth, captured on start acceptance
//   busy          out  high in every state except IDLE
//   done          out  one-cycle pulse at job completion
//   inst_w        out  array instruction: 00 hold/clear, 01 execute, 10 drain
//   acc_clr       out  accumulator clear strobe
//   feed_valid    out  qualifies array input vectors (read enable delayed 1)
//   act_rd_en     out  activation SRAM read enable
//   wgt_rd_en     out  weight SRAM read enable
//   rd_addr       out  shared activation/weight read address
//   array_valid   in   per-column psum valid from the array
//   psum_wr_en    out  psum SRAM write enable (combinational, DRAIN only)
//   psum_wr_addr  out  psum SRAM write address
//   cycle_cnt     out  job cycle count (feature macro above)
//   state_dbg     out  current FSM state encoding, for observation
//
// Handshake: start is a level request sampled only while the FSM is in IDLE.
// When sampled high there, the job is accepted and busy rises on the next
// cycle. A start seen while busy is dropped, never queued; a new job can be
// accepted at the earliest in the IDLE cycle that follows done.
// -----------------------------------------------------------------------------
module mac_array_os_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [addr_bw-1:0]      k_len,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              inst_w,
  output logic                    acc_clr,
  output logic                    feed_valid,
  output logic                    act_rd_en,
  output logic                    wgt_rd_en,
  output logic [addr_bw-1:0]      rd_addr,
  input  logic [col-1:0]          array_valid,
  output logic                    psum_wr_en,
  output logic [$clog2(row)-1:0]  psum_wr_addr,
  output logic [31:0]             cycle_cnt,
  output logic [2:0]              state_dbg
);

  localparam int FW = $clog2(row + col);
  localparam int PW = $clog2(row);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_FLUSH = 3'd3,
    S_DRAIN = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state, state_nxt;
  logic [addr_bw-1:0]  k_q, k_nxt;
  logic [addr_bw-1:0]  rd_addr_nxt;
  logic [FW-1:0]       flush_cnt, flush_nxt;
  logic [PW-1:0]       wr_addr_nxt;
  logic [1:0]          inst_nxt;

  assign state_dbg  = state;
  // A psum vector is only complete when every column reports valid.
  assign psum_wr_en = (state == S_DRAIN) && (&array_valid);

  // Next-state and counter logic.
  always_comb begin
    state_nxt   = state;
    k_nxt       = k_q;
    rd_addr_nxt = rd_addr;
    flush_nxt   = flush_cnt;
    wr_addr_nxt = psum_wr_addr;
    case (state)
      S_IDLE: begin
        if (start) begin
          k_nxt     = k_len;
          state_nxt = (k_len == '0) ? S_DONE : S_CLEAR;
        end
      end
      S_CLEAR: state_nxt = S_FEED;
      S_FEED: begin
        // rd_addr holds at k_len-1 once the last read is issued.
        if (rd_addr == k_q - 1'b1) state_nxt = S_FLUSH;
        else                       rd_addr_nxt = rd_addr + 1'b1;
      end
      S_FLUSH: begin
        // One SRAM-latency cycle plus row+col-1 skew cycles.
        if (flush_cnt == FW'(row + col - 1)) state_nxt = S_DRAIN;
        else                                 flush_nxt = flush_cnt + 1'b1;
      end
      S_DRAIN: begin
        if (psum_wr_en) begin
          if (psum_wr_addr == PW'(row - 1)) state_nxt = S_DONE;
          else                              wr_addr_nxt = psum_wr_addr + 1'b1;
        end
      end
      S_DONE: begin
        state_nxt   = S_IDLE;
        rd_addr_nxt = '0;
        flush_nxt   = '0;
        wr_addr_nxt = '0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode for the state being entered, so every output except
  // psum_wr_en comes straight from a flop.
  always_comb begin
    inst_nxt = 2'b00;
    case (state_nxt)
      S_FEED, S_FLUSH: inst_nxt = 2'b01;
      S_DRAIN:         inst_nxt = 2'b10;
      default:         inst_nxt = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      k_q          <= '0;
      rd_addr      <= '0;
      flush_cnt    <= '0;
      psum_wr_addr <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      inst_w       <= 2'b00;
      acc_clr      <= 1'b0;
      act_rd_en    <= 1'b0;
      wgt_rd_en    <= 1'b0;
      feed_valid   <= 1'b0;
    end else begin
      state        <= state_nxt;
      k_q          <= k_nxt;
      rd_addr      <= rd_addr_nxt;
      flush_cnt    <= flush_nxt;
      psum_wr_addr <= wr_addr_nxt;
      busy         <= (state_nxt != S_IDLE);
      done         <= (state_nxt == S_DONE);
      inst_w       <= inst_nxt;
      acc_clr      <= (state_nxt == S_CLEAR);
      act_rd_en    <= (state_nxt == S_FEED);
      wgt_rd_en    <= (state_nxt == S_FEED);
      // Read data arrives one cycle after the enable.
      feed_valid   <= act_rd_en;
    end
  end

`ifdef MAC_OS_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (state == S_IDLE) begin
      if (start) cycle_cnt <= '0;
    end else if (cycle_cnt != 32'hFFFF_FFFF) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_mac_array_os_ctrl.sv
// Testbench for mac_array_os_ctrl (row=col=8, addr_bw=8).
module tb_mac_array_os_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int SKEW = ROW + COL;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  k_len;
  logic        busy, done;
  logic [1:0]  inst_w;
  logic        acc_clr, feed_valid, act_rd_en, wgt_rd_en;
  logic [7:0]  rd_addr;
  logic [7:0]  array_valid;
  logic        psum_wr_en;
  logic [2:0]  psum_wr_addr;
  logic [31:0] cycle_cnt;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  mac_array_os_ctrl #(.row(ROW), .col(COL), .addr_bw(8)) dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len),
    .busy(busy), .done(done), .inst_w(inst_w), .acc_clr(acc_clr),
    .feed_valid(feed_valid), .act_rd_en(act_rd_en), .wgt_rd_en(wgt_rd_en),
    .rd_addr(rd_addr), .array_valid(array_valid), .psum_wr_en(psum_wr_en),
    .psum_wr_addr(psum_wr_addr), .cycle_cnt(cycle_cnt), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] rd_q[$];
  logic [7:0] wr_q[$];
  logic [7:0] exp_v;
  int total = 0;
  int bad = 0;
  int cyc_n, cur_k, cur_mode;
  int flush_seen = 0, clr_seen = 0, fv_seen = 0, done_seen = 0;
  int flush_base, clr_base, fv_base, done_base;

  typedef struct {
    int k;
    int mode;  // 0 all-valid drain, 1 alternating FF/7F, 2 three stalls first
    int lat;   // start acceptance edge to done, in cycles
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ctrl"}, 32'({busy, done, inst_w, acc_clr, feed_valid,
                              act_rd_en, wgt_rd_en, psum_wr_en}), 32'd0);
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'd0);
    chk({tag, "_wr_addr"}, 32'(psum_wr_addr), 32'd0);
    chk({tag, "_cycle_cnt"}, cycle_cnt, 32'd0);
  endtask

  // One clock: drive array_valid after the edge, observe at the falling edge.
  task automatic tick();
    int d;
    @(posedge clk);
    #1;
    cyc_n++;
    d = cyc_n - (cur_k + 2 + SKEW);
    if (d < 0)
      array_valid = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    else if (cur_mode == 1)
      array_valid = (d % 2 == 0) ? 8'hFF : 8'h7F;
    else if (cur_mode == 2 && d < 3)
      array_valid = (d == 1) ? 8'hFE : 8'h00;
    else
      array_valid = 8'hFF;
    @(negedge clk);
    if (reset) begin
      if (act_rd_en || wgt_rd_en) begin
        chk("rd_en_pair", 32'(wgt_rd_en), 32'(act_rd_en));
        chk("feed_inst", 32'(inst_w), 32'd1);
        if (rd_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else begin
          exp_v = rd_q.pop_front();
          chk("rd_addr_seq", 32'(rd_addr), 32'(exp_v));
        end
      end
      if (psum_wr_en) begin
        chk("drain_inst", 32'(inst_w), 32'd2);
        if (wr_q.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
        else begin
          exp_v = wr_q.pop_front();
          chk("psum_wr_addr_seq", 32'(psum_wr_addr), 32'(exp_v));
        end
      end
      if (inst_w == 2'b01 && !act_rd_en) flush_seen++;
      if (acc_clr) clr_seen++;
      if (feed_valid) fv_seen++;
      if (done) done_seen++;
    end
  endtask

  task automatic begin_job(input int k, input int mode);
    for (int i = 0; i < k; i++) rd_q.push_back(8'(i));
    if (k > 0) for (int i = 0; i < ROW; i++) wr_q.push_back(8'(i));
    cur_k = k;
    cur_mode = mode;
    cyc_n = 0;
    flush_base = flush_seen;
    clr_base = clr_seen;
    fv_base = fv_seen;
    k_len = 8'(k);
    start = 1'b1;
  endtask

  task automatic wait_done(input int exp_lat, input bit hold);
    int got;
    int exp_cnt;
    got = -1;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (!hold) start = 1'b0;
      if (done) begin
        got = cyc_n;
        break;
      end
    end
    chk("done_latency", 32'(got), 32'(exp_lat));
    chk("flush_cycles", 32'(flush_seen - flush_base), (cur_k > 0) ? 32'(SKEW) : 32'd0);
    chk("acc_clr_pulses", 32'(clr_seen - clr_base), (cur_k > 0) ? 32'd1 : 32'd0);
    chk("feed_valid_cycles", 32'(fv_seen - fv_base), 32'(cur_k));
    tick();
    chk("done_pulse_width", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_wr_addr", 32'(psum_wr_addr), 32'd0);
`ifdef MAC_OS_CTRL_PERF_EN
    exp_cnt = exp_lat;
`else
    exp_cnt = 0;
`endif
    chk("cycle_cnt", cycle_cnt, 32'(exp_cnt));
    chk("rd_q_left", 32'(rd_q.size()), 32'd0);
    chk("wr_q_left", 32'(wr_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    reset = 1'b0;
    start = 1'b0;
    k_len = 8'd0;
    array_valid = 8'd0;
    cur_k = 0;
    cur_mode = 0;
    cyc_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk_reset_vals("idle");

    // latency = 2 + k + (row+col) + drain cycles
    vecs[0] = '{k: 4,   mode: 0, lat: 30};
    vecs[1] = '{k: 0,   mode: 0, lat: 1};
    vecs[2] = '{k: 1,   mode: 1, lat: 34};
    vecs[3] = '{k: 7,   mode: 2, lat: 36};
    vecs[4] = '{k: 255, mode: 0, lat: 281};
    vecs[5] = '{k: 2,   mode: 0, lat: 28};
    for (int i = 0; i < 6; i++) begin
      begin_job(vecs[i].k, vecs[i].mode);
      wait_done(vecs[i].lat, 1'b0);
    end

    // start held through a job, k_len changed mid-FEED: first job keeps k=5,
    // the held start launches a second job (k=9) from the IDLE after done.
    begin_job(5, 0);
    tick();
    tick();
    tick();
    k_len = 8'd9;
    wait_done(31, 1'b1);
    begin_job(9, 0);
    wait_done(35, 1'b0);

    // asynchronous reset in FEED at rd_addr=2
    rd_q.push_back(8'd0);
    rd_q.push_back(8'd1);
    rd_q.push_back(8'd2);
    cur_k = 6;
    cur_mode = 0;
    cyc_n = 0;
    k_len = 8'd6;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_mid_rd_addr", 32'(rd_addr), 32'd2);
    reset = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    done_base = done_seen;
    repeat (3) tick();
    reset = 1'b1;
    repeat (2) tick();
    chk("rst_no_done", 32'(done_seen - done_base), 32'd0);
    chk("rst_rd_q_left", 32'(rd_q.size()), 32'd0);
    begin_job(3, 0);
    wait_done(29, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_array_os_ctrl.md
# mac_array_os_ctrl

Sequencer for the output-stationary MAC array. Accepts one tile job (K accumulation steps), clears array accumulators, streams K activation/weight vector reads from the input SRAMs, flushes the systolic skew, then drains `row` psum vectors from the array into the psum SRAM. Sits between the core top-level FSM and the `row`×`col` OS MAC array and SRAM ports.

## Interface
- `row`, 8, array rows; number of psum vectors drained per job
- `col`, 8, array columns; width of the `array_valid` input
- `addr_bw`, 8, SRAM address width; `k_len` max = 2^addr_bw − 1
- `clk`  in  1  clock; all state updates on its rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  job request; sampled only in IDLE
- `k_len`  in  addr_bw  accumulation depth; captured when `start` is accepted
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at job completion
- `inst_w`  out  2  array instruction: 00 = hold/clear, 01 = execute, 10 = drain
- `acc_clr`  out  1  accumulator clear strobe to the array
- `feed_valid`  out  1  qualifies the array input vectors; low forces zero inputs
- `act_rd_en`, `wgt_rd_en`  out  1 each  SRAM read enables
- `rd_addr`  out  addr_bw  shared activation/weight read address
- `array_valid`  in  col  per-column psum valid from the array
- `psum_wr_en`  out  1  psum SRAM write enable
- `psum_wr_addr`  out  $clog2(row)  psum SRAM write address
- `cycle_cnt`  out  32  job cycle count (see Configuration)

## Operation
- FSM states: IDLE, CLEAR, FEED, FLUSH, DRAIN, DONE.
- IDLE: `start`=1 → latch `k_len`; next CLEAR. If the latched `k_len`=0 → go directly to DONE. No reads or writes occur.
- CLEAR: 1 cycle; `acc_clr`=1, `inst_w`=00 → FEED.
- FEED: k_len cycles; `act_rd_en`=`wgt_rd_en`=1; `rd_addr`=0…k_len−1, incrementing by one per cycle; `inst_w`=01. After the last address → FLUSH.
- FLUSH: `row`+`col` cycles. This is one SRAM-latency cycle plus `row`+`col`−1 skew cycles. During FLUSH: `inst_w`=01, read enables = 0, `feed_valid` follows the delayed read enable.
- `feed_valid` is the read enable delayed by one cycle, which matches the 1-cycle SRAM read latency.
- DRAIN: `inst_w`=10. `psum_wr_en`=`&array_valid`. `psum_wr_addr` starts at 0 and increments after each write. Exit to DONE after exactly `row` writes. Cycles with partial or zero valid are waited out; there is no timeout.
- DONE: 1 cycle; `done`=1 → IDLE. A new `start` is accepted no earlier than the following IDLE cycle.
- `start` asserted while `busy`=1 is ignored and is not queued.
- `k_len` changes after acceptance have no effect on the running job.
- Counters never wrap within a job. `rd_addr` tops out at k_len−1. `psum_wr_addr` tops out at `row`−1 and returns to 0 in IDLE.

## Timing
- Reset value of all outputs: `busy`=0, `done`=0, `inst_w`=00, `acc_clr`=0, `feed_valid`=0, `act_rd_en`=`wgt_rd_en`=0, `rd_addr`=0, `psum_wr_en`=0, `psum_wr_addr`=0, `cycle_cnt`=0. FSM resets to IDLE.
- Reset asserted mid-job: all state and outputs clear immediately (asynchronously) to reset values. No `done` pulse is produced. Release of reset resumes in IDLE.
- All outputs are registered except `psum_wr_en`, which is combinational from `array_valid` and the DRAIN state.
- `start` at edge t → `busy`=1 and CLEAR at t+1 → first read at t+2.
- Total job latency, `start` edge to `done` high, with `array_valid` all-high throughout DRAIN: 1 + 1 + k_len + (`row`+`col`) + `row` cycles.
- With k_len=0: `done` is high at t+1.

## Configuration
- `MAC_OS_CTRL_PERF_EN` defined:
  - `cycle_cnt` clears on `start` acceptance.
  - It increments every cycle while `busy`=1.
  - It holds its value through IDLE until the next accepted `start`.
  - It saturates at 2^32−1.
- Not defined: `cycle_cnt` is tied to 0 and no counter logic is synthesised.

## Test plan
- Reset, then `start` with k_len=4, row=col=8, `array_valid`=all-1 in DRAIN → expect:
  - `rd_addr` sequence 0,1,2,3;
  - 16 FLUSH cycles;
  - 8 psum writes to addresses 0..7;
  - `done` 30 cycles after `start`;
  - `cycle_cnt`=30 with PERF_EN.
- k_len=0 → `done` pulses at t+1; no read enables and no `psum_wr_en` ever assert.
- DRAIN with `array_valid` alternating between 0xFF and 0x7F → a write happens only on 0xFF cycles; still exactly 8 writes; `done` is delayed accordingly.
- `start` held high for the whole job and `k_len` changed mid-FEED → only the first job runs with the original `k_len`. A second job begins in the cycle after `done`.
- Reset asserted in FEED at `rd_addr`=2 → all outputs go to 0 immediately, no `done` pulse. A subsequent `start` with k_len=3 completes normally.
- k_len=255 → `rd_addr` reaches 254 with no wrap; `done` arrives 1+1+255+16+8 = 281 cycles after `start`.
